// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
// The optional per-channel drain counters are enabled with the
// STREAM_DEMUX_STATS_EN macro in the top-level file.
package stream_demux_pkg;

   // The output register is either free or holds one beat plus its destination.
   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   // Width of each per-channel drain counter.
   localparam int STATS_W = 16;

   // Counter increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
      return (v == {STATS_W{1'b1}}) ? v : v + STATS_W'(1);
   endfunction

endpackage

// File: rtl/stream_demux_rr_ptr.sv
// Modulo-N wrap counter for round-robin steering.
// The pointer moves by one on each enabled cycle and wraps from N-1 back to 0.
module stream_demux_rr_ptr #(
   parameter int N     = 4,
   parameter int SEL_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv_i,
   output logic [SEL_W-1:0] ptr_o
);

   logic [SEL_W-1:0] ptr_q;
   logic [SEL_W-1:0] ptr_d;

   // Next pointer: step by one on advance, wrapping at the last channel.
   always_comb begin
      ptr_d = ptr_q;
      if (adv_i) begin
         if (32'(ptr_q) == N - 1) begin
            ptr_d = '0;
         end else begin
            ptr_d = ptr_q + SEL_W'(1);
         end
      end
   end

   // Pointer register; reset points at channel 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demultiplexer.
// A single producer stream is steered into one of N consumer channels,
// either by an explicit select or round-robin. One output register holds
// the beat in flight; it refills on the same cycle it drains.
// Handshake: a beat moves across a port on a rising edge where that port's
// valid and ready are both high; valid never depends on ready of the same port.
// Optional feature: define STREAM_DEMUX_STATS_EN to add the beat_cnt port
// with one saturating drain counter per channel.
module stream_demux_1xn
   import stream_demux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SEL_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] out_data,
   output logic [N-1:0]     out_valid,
   input  logic [N-1:0]     out_ready,
   output logic             sel_err,
   output logic [SEL_W-1:0] rr_ptr
`ifdef STREAM_DEMUX_STATS_EN
   ,
   output logic [N*STATS_W-1:0] beat_cnt
`endif
);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] dst_q, dst_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             sel_err_q, sel_err_d;

   logic             drain;
   logic             accept;
   logic             dst_bad;
   logic             fwd;
   logic             drop;
   logic [SEL_W-1:0] acc_dst;
   logic             rr_adv;

   // Handshake decode: drain of the held beat, acceptance of a new one, and
   // whether the new beat is forwarded or discarded for an out-of-range select.
   always_comb begin
      drain    = (state_q == ST_FULL) && out_ready[dst_q];
      in_ready = (state_q == ST_EMPTY) || out_ready[dst_q];
      accept   = in_valid && in_ready;
      acc_dst  = mode ? rr_ptr : sel;
      dst_bad  = !mode && (32'(sel) >= N);
      fwd      = accept && !dst_bad;
      drop     = accept && dst_bad;
      rr_adv   = fwd && mode;
   end

   // Next-state logic for the output register and its destination.
   always_comb begin
      state_d   = state_q;
      dst_d     = dst_q;
      data_d    = data_q;
      sel_err_d = drop;
      if (fwd) begin
         state_d = ST_FULL;
         dst_d   = acc_dst;
         data_d  = in_data;
      end else if (drain) begin
         state_d = ST_EMPTY;
      end
   end

   // Output register, destination and error pulse; reset drops any held beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         dst_q     <= '0;
         data_q    <= '0;
         sel_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dst_q     <= dst_d;
         data_q    <= data_d;
         sel_err_q <= sel_err_d;
      end
   end

   // One-hot valid toward the destination channel only while a beat is held.
   always_comb begin
      out_valid = '0;
      for (int k = 0; k < N; k++) begin
         out_valid[k] = (state_q == ST_FULL) && (32'(dst_q) == k);
      end
   end

   assign out_data = data_q;
   assign sel_err  = sel_err_q;

   stream_demux_rr_ptr #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_rr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .adv_i (rr_adv),
      .ptr_o (rr_ptr)
   );

`ifdef STREAM_DEMUX_STATS_EN
   logic [STATS_W-1:0] cnt_q [N];
   logic [STATS_W-1:0] cnt_d [N];

   // Count each drain on its channel, sticking at the counter maximum.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         cnt_d[k] = cnt_q[k];
         if (drain && (32'(dst_q) == k)) begin
            cnt_d[k] = sat_inc(cnt_q[k]);
         end
      end
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   // Flatten the counters onto the port, channel 0 in the low bits.
   always_comb begin
      beat_cnt = '0;
      for (int k = 0; k < N; k++) begin
         beat_cnt[k*STATS_W +: STATS_W] = cnt_q[k];
      end
   end
`endif

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Testbench for stream_demux_1xn: an N=4 instance checked by a scoreboard
// against a queue-based reference model, plus an N=3 instance for the
// out-of-range select path. Counter checks compile in with STREAM_DEMUX_STATS_EN.
module tb_stream_demux_1xn;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int SW = 2;
   localparam int N3 = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- N=4 instance ----------------
   logic          mode = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [SW-1:0] sel = '0;
   logic [W-1:0]  out_data;
   logic [N-1:0]  out_valid;
   logic [N-1:0]  out_ready = '0;
   logic          sel_err;
   logic [SW-1:0] rr_ptr;
`ifdef STREAM_DEMUX_STATS_EN
   logic [N*16-1:0]  beat_cnt;
   logic [N3*16-1:0] beat_cnt3;
`endif

   stream_demux_1xn #(.WIDTH(W), .N(N), .SEL_W(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sel_err   (sel_err),
      .rr_ptr    (rr_ptr)
`ifdef STREAM_DEMUX_STATS_EN
      ,
      .beat_cnt  (beat_cnt)
`endif
   );

   // ---------------- N=3 instance ----------------
   logic          mode3 = 1'b0;
   logic [W-1:0]  in_data3 = '0;
   logic          in_valid3 = 1'b0;
   logic          in_ready3;
   logic [1:0]    sel3 = '0;
   logic [W-1:0]  out_data3;
   logic [N3-1:0] out_valid3;
   logic [N3-1:0] out_ready3 = '1;
   logic          sel_err3;
   logic [1:0]    rr_ptr3;

   stream_demux_1xn #(.WIDTH(W), .N(N3), .SEL_W(2)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode3),
      .in_data   (in_data3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .sel       (sel3),
      .out_data  (out_data3),
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .sel_err   (sel_err3),
      .rr_ptr    (rr_ptr3)
`ifdef STREAM_DEMUX_STATS_EN
      ,
      .beat_cnt  (beat_cnt3)
`endif
   );

   // ---------------- counters and compare helper ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Each queue entry is {destination, data}; the block holds at most one beat,
   // so the queue never grows beyond one entry.
   logic [SW+W-1:0] exp_q[$];
   int              rr_m = 0;
   logic            err_m = 1'b0;
   logic [W-1:0]    last_m = '0;
   int              cnt_m [N];
   bit              mon_en = 1'b0;

   function automatic bit model_ready();
      if (exp_q.size() == 0) return 1'b1;
      return out_ready[exp_q[0][SW+W-1:W]];
   endfunction

   task automatic model_clear();
      exp_q.delete();
      rr_m   = 0;
      err_m  = 1'b0;
      last_m = '0;
      for (int k = 0; k < N; k++) cnt_m[k] = 0;
   endtask

   initial model_clear();

   // Model update at each rising edge from the inputs held since the last edge.
   always @(posedge clk) begin
      bit rdy;
      bit acc;
      int d;
      if (!rst_n) begin
         model_clear();
      end else begin
         rdy   = model_ready();
         acc   = in_valid && rdy;
         err_m = 1'b0;
         if (exp_q.size() != 0 && out_ready[exp_q[0][SW+W-1:W]]) begin
            d = int'(exp_q[0][SW+W-1:W]);
            if (cnt_m[d] < 65535) cnt_m[d] = cnt_m[d] + 1;
            void'(exp_q.pop_front());
         end
         if (acc) begin
            if (mode) begin
               exp_q.push_back({SW'(rr_m), in_data});
               last_m = in_data;
               rr_m   = (rr_m + 1) % N;
            end else if (int'(sel) >= N) begin
               err_m = 1'b1;
            end else begin
               exp_q.push_back({sel, in_data});
               last_m = in_data;
            end
         end
      end
   end

   // Monitor: compare the DUT's presented outputs against the model mid-cycle.
   always @(negedge clk) begin
      logic [N-1:0] ev;
      if (rst_n && mon_en) begin
         ev = '0;
         if (exp_q.size() != 0) ev[exp_q[0][SW+W-1:W]] = 1'b1;
         check("out_valid", 32'(out_valid), 32'(ev));
         check("out_data", 32'(out_data), 32'(last_m));
         check("in_ready", 32'(in_ready), 32'(model_ready()));
         check("rr_ptr", 32'(rr_ptr), 32'(rr_m));
         check("sel_err", 32'(sel_err), 32'(err_m));
`ifdef STREAM_DEMUX_STATS_EN
         for (int k = 0; k < N; k++) begin
            check("beat_cnt", 32'(beat_cnt[k*16 +: 16]), 32'(cnt_m[k]));
         end
`endif
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input bit v, input logic [W-1:0] d, input logic [SW-1:0] s,
                        input bit m, input logic [N-1:0] r);
      in_valid  = v;
      in_data   = d;
      sel       = s;
      mode      = m;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset values while held in reset
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data", 32'(out_data), 32'h0);
      check("rst_rr_ptr", 32'(rr_ptr), 32'h0);
      check("rst_sel_err", 32'(sel_err), 32'h0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'h1);
      mon_en = 1'b1;

      // Mode 0, explicit select to each channel back to back
      for (int i = 0; i < N; i++) drive(1'b1, W'(8'hA0 + i), SW'(i), 1'b0, '1);
      drive(1'b0, '0, '0, 1'b0, '1);

      // Mode 0, channel 2 stalled for three cycles, then drains with refill
      drive(1'b1, 8'hB0, 2'd2, 1'b0, 4'b1111);
      repeat (3) drive(1'b1, 8'hB1, 2'd1, 1'b0, 4'b1011);
      drive(1'b1, 8'hB1, 2'd1, 1'b0, 4'b1111);
      drive(1'b0, '0, '0, 1'b0, 4'b1111);

      // Mode 1, six beats round-robin with wrap
      for (int i = 0; i < 6; i++) drive(1'b1, W'(8'hC0 + i), SW'($urandom_range(0, 3)), 1'b1, '1);
      drive(1'b0, '0, '0, 1'b1, '1);

      // Randomised traffic, modes mixed, random back-pressure
      for (int i = 0; i < 600; i++) begin
         drive(bit'($urandom_range(0, 3) != 0), W'($urandom), SW'($urandom_range(0, 3)),
               bit'($urandom_range(0, 1)), N'($urandom));
      end
      drive(1'b0, '0, '0, 1'b0, '1);
      drive(1'b0, '0, '0, 1'b0, '1);

      // N=3: out-of-range select is dropped with a one-cycle error pulse
      in_valid3 = 1'b1;
      sel3      = 2'd3;
      in_data3  = 8'h55;
      mode3     = 1'b0;
      @(negedge clk);
      check("n3_in_ready", 32'(in_ready3), 32'h1);
      @(posedge clk);
      #1;
      in_valid3 = 1'b0;
      @(negedge clk);
      check("n3_sel_err_pulse", 32'(sel_err3), 32'h1);
      check("n3_drop_out_valid", 32'(out_valid3), 32'h0);
      check("n3_drop_rr_ptr", 32'(rr_ptr3), 32'h0);
      check("n3_drop_out_data", 32'(out_data3), 32'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("n3_sel_err_end", 32'(sel_err3), 32'h0);
      @(posedge clk);
      #1;
      in_valid3 = 1'b1;
      sel3      = 2'd2;
      in_data3  = 8'h66;
      @(posedge clk);
      #1;
      in_valid3 = 1'b0;
      @(negedge clk);
      check("n3_sel2_out_valid", 32'(out_valid3), 32'h4);
      check("n3_sel2_out_data", 32'(out_data3), 32'h66);
      check("n3_sel2_sel_err", 32'(sel_err3), 32'h0);
      @(posedge clk);
      #1;
      // N=3 round-robin wraps 0,1,2,0
      mode3 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid3 = 1'b1;
         in_data3  = W'(8'h70 + i);
         @(posedge clk);
         #1;
         check("n3_rr_ptr", 32'(rr_ptr3), 32'((i + 1) % 3));
         check("n3_rr_out_valid", 32'(out_valid3), 32'(1 << (i % 3)));
      end
      in_valid3 = 1'b0;

`ifdef STREAM_DEMUX_STATS_EN
      // Channel 1 counter driven past its limit
      for (int i = 0; i < 65540; i++) drive(1'b1, W'(i), 2'd1, 1'b0, '1);
      drive(1'b0, '0, '0, 1'b0, '1);
      check("cnt1_saturated", 32'(beat_cnt[16 +: 16]), 32'hFFFF);
`endif

      // Reset while a beat is held
      drive(1'b1, 8'hE1, 2'd3, 1'b0, 4'b0000);
      drive(1'b0, '0, '0, 1'b0, 4'b0000);
      check("pre_rst_out_valid", 32'(out_valid), 32'h8);
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'h0);
      check("mid_rst_out_data", 32'(out_data), 32'h0);
      check("mid_rst_rr_ptr", 32'(rr_ptr), 32'h0);
`ifdef STREAM_DEMUX_STATS_EN
      check("mid_rst_beat_cnt", 32'(|beat_cnt), 32'h0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b0, '0, '0, 1'b0, '1);
      // Traffic after reset: nothing replayed, fresh beats flow
      for (int i = 0; i < 8; i++) drive(1'b1, W'(8'hF0 + i), SW'(i % 4), bit'(i / 4), '1);
      drive(1'b0, '0, '0, 1'b0, '1);
      drive(1'b0, '0, '0, 1'b0, '1);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
